// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares a single synchronous-read ROM (registered output, one cycle after the
// read enable) between NUM_REQ requesters. Requests are granted round-robin,
// with at most one ROM read per cycle. Returned words are held in a 2-entry
// response FIFO, so backpressure on the response side never loses data.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2)
//   ADDR_W   ROM address width
//   DATA_W   ROM word width (signed, passed through unchanged)
//   ID_W     requester id width, derived from NUM_REQ
//
// Ports:
//   clk             clock, all state on rising edge
//   rst_n           asynchronous active-low reset
//   req_valid       per-requester read request
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready       one-hot (or zero) accept, transfer when valid & ready
//   rom_read        ROM read enable
//   rom_addr        ROM address, holds its last value while idle
//   rom_data        ROM output, valid the cycle after rom_read
//   rsp_valid       response FIFO head is valid
//   rsp_ready       consumer accepts the head response
//   rsp_id          requester index of the head response
//   rsp_data        signed ROM word of the head response
//   stat_grant_cnt  (ARB_STATS_EN only) 16-bit saturating grant counters,
//                   requester i at [i*16 +: 16]
//
// Optional feature macro: ARB_STATS_EN
// ---------------------------------------------------------------------------
module rom_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 5,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rom_read,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic signed [DATA_W-1:0]  rom_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic signed [DATA_W-1:0]  rsp_data
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grant_cnt
`endif
);

  logic [ID_W-1:0]          rr_ptr;
  logic                     pend;
  logic [ID_W-1:0]          pend_id;
  logic [ADDR_W-1:0]        last_addr;

  logic [ID_W-1:0]          buf_id   [2];
  logic signed [DATA_W-1:0] buf_data [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               occ;

  logic                     pop;
  logic [2:0]               fill;
  logic                     credit;
  logic                     found;
  logic [ID_W-1:0]          cand;
  logic [ID_W-1:0]          win_id;
  logic [NUM_REQ-1:0]       grant;

  // Credit accounting: the buffer must be able to absorb every word already
  // in flight plus the one a new grant would launch. A pop in this cycle
  // frees a slot in time for the next push, which is what lets sustained
  // 1-per-cycle throughput coexist with a 2-entry buffer.
  always_comb begin
    pop    = rsp_valid & rsp_ready;
    fill   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    credit = (fill < 3'd2);
  end

  // Round-robin search starting one past the last winner and wrapping.
  // Grants are also suppressed while reset is asserted so the request side
  // reads all-zero immediately on reset, not only after the next edge.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    win_id = '0;
    grant  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    if (found && credit && rst_n) begin
      grant[win_id] = 1'b1;
    end
  end

  // ROM request side. The address follows the winner while granting and
  // otherwise keeps the last issued address so the ROM pins stay quiet.
  always_comb begin
    req_ready = grant;
    rom_read  = |grant;
    rom_addr  = last_addr;
    if (rom_read) begin
      rom_addr = req_addr[win_id*ADDR_W +: ADDR_W];
    end
  end

  // Arbitration state: pointer advances to each winner, and pend tracks the
  // read whose data appears on rom_data during the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      pend      <= 1'b0;
      pend_id   <= '0;
      last_addr <= '0;
    end else begin
      pend <= rom_read;
      if (rom_read) begin
        rr_ptr    <= win_id;
        pend_id   <= win_id;
        last_addr <= rom_addr;
      end
    end
  end

  // Response FIFO. Entries are fully registered so nothing from rom_data
  // reaches the response outputs combinationally. Push and pop in the same
  // cycle leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_id[i]   <= '0;
        buf_data[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (pend) begin
        buf_id[wr_ptr]   <= pend_id;
        buf_data[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, pend} - {1'b0, pop};
    end
  end

  always_comb begin
    rsp_valid = (occ != 2'd0);
    rsp_id    = buf_id[rd_ptr];
    rsp_data  = buf_data[rd_ptr];
  end

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Per-requester grant counters, saturating so long runs never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt[i] != 16'hFFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grant_cnt[i*16 +: 16] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Directed bench for rom_read_arbiter with a behavioural registered-read ROM.
// ROM contents: word[a] = a ^ 5'b10100, so word[7] = 5'b10011 (-13).
// Define ARB_STATS_EN to also exercise the saturating grant counters.
// ---------------------------------------------------------------------------
module tb_rom_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 5;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rom_read;
  logic [ADDR_W-1:0]         rom_addr;
  logic signed [DATA_W-1:0]  rom_data = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [ID_W-1:0]           rsp_id;
  logic signed [DATA_W-1:0]  rsp_data;
`ifdef ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     stat_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rom_read_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rom_read (rom_read),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
`ifdef ARB_STATS_EN
    .stat_grant_cnt(stat_grant_cnt),
`endif
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_val(input int a);
    logic [DATA_W-1:0] av;
    av = DATA_W'(a);
    return av ^ 5'b10100;
  endfunction

  // Sign-extended expected response word for address a.
  function automatic logic [31:0] expData(input int a);
    logic [DATA_W-1:0] v;
    v = rom_val(a);
    return {{(32-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [NUM_REQ*ADDR_W-1:0] packAddr(input int a0, input int a1,
                                                         input int a2, input int a3);
    return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  // Behavioural ROM: registered read, gated by the read enable.
  always @(posedge clk) begin
    if (rom_read) begin
      rom_data <= $signed(rom_val(int'(rom_addr)));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive new inputs just after the edge, then let the
  // combinational outputs settle before any checks.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                               input logic [NUM_REQ*ADDR_W-1:0] addr,
                               input logic ready);
    @(posedge clk);
    #1;
    req_valid = valid;
    req_addr  = addr;
    rsp_ready = ready;
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset values.
    #2;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_rom_read",  32'(rom_read),  32'h0);
    checkOutput("reset_rom_addr",  32'(rom_addr),  32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("reset_rsp_data",  rsp_data,       32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2 at address 7.
    $display("[TB] single request");
    applyStimulus(4'b0100, packAddr(0, 0, 7, 0), 1'b0);
    checkOutput("t1_req_ready", 32'(req_ready), 32'h4);
    checkOutput("t1_rom_read",  32'(rom_read),  32'h1);
    checkOutput("t1_rom_addr",  32'(rom_addr),  32'd7);
    checkOutput("t1_rsp_valid0", 32'(rsp_valid), 32'h0);
    applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b0);
    checkOutput("t1_idle_ready", 32'(req_ready), 32'h0);
    checkOutput("t1_addr_hold",  32'(rom_addr),  32'd7);
    checkOutput("t1_rsp_valid1", 32'(rsp_valid), 32'h0);
    applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);
    checkOutput("t1_rsp_valid2", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_id",     32'(rsp_id),    32'd2);
    checkOutput("t1_rsp_data",   rsp_data,       32'hFFFF_FFF3);
    applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);
    checkOutput("t1_rsp_popped", 32'(rsp_valid), 32'h0);

    // All requesters valid with a free consumer: 0,1,2,3,0,... no bubbles.
    $display("[TB] full round robin");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, packAddr(1, 2, 3, 4), 1'b1);
      checkOutput($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      checkOutput($sformatf("t2_addr_%0d", k),  32'(rom_addr),  32'((k % 4) + 1));
      if (k >= 2) begin
        checkOutput($sformatf("t2_rsp_valid_%0d", k), 32'(rsp_valid), 32'h1);
        checkOutput($sformatf("t2_rsp_id_%0d", k),    32'(rsp_id),    32'((k - 2) % 4));
        checkOutput($sformatf("t2_rsp_data_%0d", k),  rsp_data,       expData(((k - 2) % 4) + 1));
      end
    end
    repeat (3) applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);
    checkOutput("t2_drained", 32'(rsp_valid), 32'h0);

    // Backpressure: exactly two accepts, then stall until a pop.
    $display("[TB] backpressure");
    applyStimulus(4'b0001, packAddr(9, 0, 0, 0), 1'b0);
    checkOutput("t3_accept0", 32'(req_ready), 32'h1);
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b0);
    checkOutput("t3_accept1", 32'(req_ready), 32'h1);
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b0);
    checkOutput("t3_stall0", 32'(req_ready), 32'h0);
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b0);
    checkOutput("t3_stall1", 32'(req_ready), 32'h0);
    checkOutput("t3_full_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t3_full_data",  rsp_data,       expData(9));
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b1);
    checkOutput("t3_resume0", 32'(req_ready), 32'h1);
    checkOutput("t3_head0",   rsp_data,       expData(9));
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b1);
    checkOutput("t3_resume1", 32'(req_ready), 32'h1);
    checkOutput("t3_head1_v", 32'(rsp_valid), 32'h1);
    checkOutput("t3_head1",   rsp_data,       expData(10));
    applyStimulus(4'b0001, packAddr(10, 0, 0, 0), 1'b1);
    checkOutput("t3_resume2", 32'(req_ready), 32'h1);
    checkOutput("t3_head2",   rsp_data,       expData(10));
    repeat (4) applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);
    checkOutput("t3_drained", 32'(rsp_valid), 32'h0);

    // Fairness between requesters 1 and 3 after a grant to 3.
    $display("[TB] fairness");
    applyStimulus(4'b1000, packAddr(0, 3, 0, 4), 1'b1);
    checkOutput("t4_prime", 32'(req_ready), 32'h8);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1010, packAddr(0, 3, 0, 4), 1'b1);
      checkOutput($sformatf("t4_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
    end
    repeat (4) applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);

    // Reset while a read is in flight and the buffer holds data.
    $display("[TB] reset mid-operation");
    applyStimulus(4'b0001, packAddr(5, 0, 0, 0), 1'b0);
    applyStimulus(4'b0001, packAddr(6, 0, 0, 0), 1'b0);
    applyStimulus(4'b0001, packAddr(6, 0, 0, 0), 1'b0);
    checkOutput("t5_pre_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_req_ready", 32'(req_ready), 32'h0);
    checkOutput("t5_rom_read",  32'(rom_read),  32'h0);
    checkOutput("t5_rom_addr",  32'(rom_addr),  32'h0);
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t5_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("t5_rsp_data",  rsp_data,       32'h0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);
    checkOutput("t5_no_rsp", 32'(rsp_valid), 32'h0);
    applyStimulus(4'b1010, packAddr(0, 3, 0, 4), 1'b1);
    checkOutput("t5_first_grant", 32'(req_ready), 32'h2);
    repeat (3) applyStimulus(4'b0000, packAddr(0, 0, 0, 0), 1'b1);

`ifdef ARB_STATS_EN
    // Saturating grant counter for requester 0.
    $display("[TB] grant statistics");
    doReset();
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    req_addr  = packAddr(1, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stat_req0", 32'(stat_grant_cnt[15:0]),  32'hFFFF);
    checkOutput("stat_req1", 32'(stat_grant_cnt[31:16]), 32'h0);
    checkOutput("stat_req2", 32'(stat_grant_cnt[47:32]), 32'h0);
    checkOutput("stat_req3", 32'(stat_grant_cnt[63:48]), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
